// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit and its neighbours (ctrl shares CPU_WIDTH).
// Also holds the ebreak encoding used when IFU_EBREAK_HALT_EN is defined.
package ifu_pkg;

    localparam int          CPU_WIDTH        = 32;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;

    localparam logic [1:0] IFU_REQ  = 2'd0;
    localparam logic [1:0] IFU_WAIT = 2'd1;
    localparam logic [1:0] IFU_DROP = 2'd2;

    function automatic logic is_ebreak(input logic [31:0] word);
        return (word == INST_EBREAK);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry synchronous FIFO holding {instruction, pc} pairs for the decoder.
// Flush empties it and wins over a push or pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] entry_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             push_en_s;
    logic             pop_en_s;
    logic [1:0]       count_next_s;

    // Qualify push/pop against occupancy and derive the next count
    always_comb begin
        pop_en_s     = pop && (count_r != 2'd0);
        push_en_s    = push && ((count_r != 2'd2) || pop_en_s);
        count_next_s = count_r;
        case ({push_en_s, pop_en_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                entry_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_en_s) begin
                entry_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_en_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != 2'd0);
    assign head_data  = entry_r[rd_ptr_r];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, one-outstanding fetch FSM and a 2-entry buffer to ctrl.
// Optional IFU_EBREAK_HALT_EN stops fetching after an ebreak is buffered until redirect or reset.
module ifu
    import ifu_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  INST_WIDTH = CPU_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc
);

    logic [1:0]                     state_r;
    logic [1:0]                     state_next_s;
    logic [PC_WIDTH-1:0]            pc_r;
    logic [PC_WIDTH-1:0]            pc_next_s;
    logic [PC_WIDTH-1:0]            out_pc_r;
    logic                           halt_s;
    logic                           req_valid_s;
    logic                           fire_s;
    logic                           push_s;
    logic                           pop_s;
    logic [1:0]                     fifo_count_s;
    logic [INST_WIDTH+PC_WIDTH-1:0] head_s;

`ifdef IFU_EBREAK_HALT_EN
    logic halt_r;

    // Halt after an ebreak enters the buffer; a redirect resumes fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_r <= 1'b0;
        end else if (redirect_valid) begin
            halt_r <= 1'b0;
        end else if (push_s && is_ebreak(imem_rsp_data)) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

    assign halt_s = halt_r;
`else
    assign halt_s = 1'b0;
`endif

    assign req_valid_s = (state_r == IFU_REQ) && (fifo_count_s != 2'd2) &&
                         !redirect_valid && rst_n && !halt_s;
    assign fire_s      = req_valid_s && imem_req_ready;
    assign push_s      = (state_r == IFU_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop_s       = inst_valid && inst_ready;

    // Next state and PC; a redirect turns an outstanding fetch into one to discard
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        if (redirect_valid) begin
            pc_next_s = redirect_pc;
            case (state_r)
                IFU_WAIT: state_next_s = imem_rsp_valid ? IFU_REQ : IFU_DROP;
                IFU_DROP: state_next_s = imem_rsp_valid ? IFU_REQ : IFU_DROP;
                default:  state_next_s = IFU_REQ;
            endcase
        end else begin
            case (state_r)
                IFU_REQ: begin
                    if (fire_s) begin
                        state_next_s = IFU_WAIT;
                        pc_next_s    = pc_r + PC_WIDTH'(4);
                    end else begin
                        state_next_s = IFU_REQ;
                    end
                end
                IFU_WAIT: state_next_s = imem_rsp_valid ? IFU_REQ : IFU_WAIT;
                IFU_DROP: state_next_s = imem_rsp_valid ? IFU_REQ : IFU_DROP;
                default:  state_next_s = IFU_REQ;
            endcase
        end
    end

    // FSM, PC and outstanding-request PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IFU_REQ;
            pc_r     <= RESET_PC;
            out_pc_r <= '0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            out_pc_r <= fire_s ? pc_r : out_pc_r;
        end
    end

    ifu_fifo #(
        .WIDTH(INST_WIDTH + PC_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  ({imem_rsp_data, out_pc_r}),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .count      (fifo_count_s),
        .head_valid (inst_valid),
        .head_data  (head_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign inst           = head_s[INST_WIDTH+PC_WIDTH-1:PC_WIDTH];
    assign inst_pc        = head_s[PC_WIDTH-1:0];

endmodule
